fp_alu_stream: RTL and testbench
================================

FP_ALU_STREAM -- requirements
Module: fp_alu_stream

Interface
REQ-001 SHALL have parameter BUS_W, default 8, giving the data beat width; legal values are 8, 16 and 32.
REQ-002 SHALL have parameter EXEC_LAT, default 1, giving the execute cycles from the last operand beat to result capture; legal range is 1..4.
REQ-003 SHALL define derived constant BEATS = 32/BUS_W, the number of beats per operand and per result.
REQ-004 SHALL have port clk, input, 1 bit: the clock. All state updates occur on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: the reset. Asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-007 SHALL have port opcode, input, 2 bits, sampled with start: 00 add (a+b), 01 sub (a-b), 10 reverse sub (b-a), 11 reserved.
REQ-008 SHALL have port in_data, input, BUS_W bits: operand beat, LSB slice first.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-011 SHALL have port out_data, output, BUS_W bits: result beat, LSB slice first.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts a beat.
REQ-014 SHALL have port out_last, output, 1 bit: marks the final result beat.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 SHALL have port op_err, output, 1 bit: a reserved opcode was latched.
REQ-017 SHALL have port state_out, output, 3 bits: the current FSM state, for debug.

Function
REQ-018 SHALL implement FSM states IDLE=0, LOAD_A=1, LOAD_B=2, EXEC=3, OUT=4; all other encodings SHALL return to IDLE.
REQ-019 SHALL, in IDLE with start=1, latch opcode, clear the beat counter, set op_err=(opcode==11), and go to LOAD_A next cycle; start outside IDLE SHALL be ignored.
REQ-020 SHALL drive in_ready=1 only in LOAD_A and LOAD_B.
REQ-021 SHALL transfer an input beat only when in_valid and in_ready are both 1; beat k SHALL fill operand bits [k*BUS_W +: BUS_W].
REQ-022 SHALL hold state and counter on a cycle with in_valid=0 (gaps allowed).
REQ-023 SHALL, on beat BEATS-1, move LOAD_A->LOAD_B or LOAD_B->EXEC and clear the counter.
REQ-024 SHALL remain in EXEC exactly EXEC_LAT cycles, capture the result register on the last EXEC cycle, then go to OUT.
REQ-025 SHALL feed fp_addsub with (a,b,sub=0) for 00, (a,b,1) for 01, (b,a,1) for 10, and (a,b,0) for 11 (reserved executes as add).
REQ-026 SHALL drive out_valid=1 throughout OUT, out_data=result slice [k*BUS_W +: BUS_W], and out_last=(k==BEATS-1).
REQ-027 SHALL hold out_data, out_last and out_valid stable while out_ready=0.
REQ-028 SHALL advance k on each out_valid and out_ready transfer; the final transfer SHALL return to IDLE with out_valid=0 the following cycle.
REQ-029 SHALL set latency, with zero stalls and BUS_W=8, EXEC_LAT=1, so that start is sampled in cycle T, input beats transfer in T+1..T+8, EXEC is T+9, and out_valid rises at T+10.
REQ-030 SHALL hold op_err until the next accepted start.

Reset
REQ-031 SHALL, on rst_n=0 at any time including mid-operation, immediately force state=IDLE, counter=0, operands=0, result=0, out_data=0, out_valid=0, out_last=0, in_ready=0, busy=0, op_err=0; partial data SHALL be discarded.
REQ-032 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-033 SHALL place the state encodings, opcode encodings and legal-parameter checks in the shared package fp_alu_pkg.
REQ-034 SHALL instantiate fp_addsub unchanged as the single sub-module; the EXEC_LAT timing SHALL be a local counter only.

Verification
REQ-035 SHALL cover add with BUS_W=8: a=0x3F800000, b=0x40000000, op 00 -> out beats 00,00,40,40, out_last on beat 4.
REQ-036 SHALL cover sub and reverse sub with the same operands: op 01 -> 0xBF800000; op 10 -> 0x3F800000.
REQ-037 SHALL cover back-pressure: random in_valid gaps and out_ready held low for 3 cycles per beat -> identical beats, no drops or duplicates.
REQ-038 SHALL cover reset mid-operation: rst_n pulsed during LOAD_B beat 2 -> all outputs at reset values; a new add then yields the correct result.
REQ-039 SHALL cover BUS_W=32, EXEC_LAT=4: one input beat each for a and b, out_valid 5 cycles after the b beat, out_last=1 on the single beat.
REQ-040 SHALL cover the reserved opcode: op 11 -> op_err=1 and the add result 0x40400000; op_err clears on the next start.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// Shared encodings and parameter legality checks for the streaming FP add/sub ALU.
package fp_alu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_RSUB = 2'b10,
        OP_RSV  = 2'b11
    } opcode_t;

    function automatic bit bus_w_legal(input int w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

    function automatic bit exec_lat_legal(input int l);
        return (l >= 1) && (l <= 4);
    endfunction

endpackage

// File: rtl/fp_addsub.sv
// Combinational single-precision add/subtract: round-to-nearest-even, denormals flush to zero.
module fp_addsub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] y
);
    logic        sb, big_s, sml_s, eff_sub, sticky, found, rnd;
    logic [30:0] big, sml, body;
    logic [7:0]  d;
    logic [26:0] mx, my, my_sh;
    logic [27:0] w;
    logic [9:0]  e;
    logic [4:0]  lz;

    always_comb begin
        sb = b[31] ^ sub;
        if (a[30:0] >= b[30:0]) begin
            big = a[30:0]; sml = b[30:0]; big_s = a[31]; sml_s = sb;
        end else begin
            big = b[30:0]; sml = a[30:0]; big_s = sb; sml_s = a[31];
        end
        eff_sub = big_s ^ sml_s;
        d  = big[30:23] - sml[30:23];
        mx = {big[30:23] != 8'd0, big[22:0], 3'b000};
        my = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
        if (d > 8'd26) begin
            my_sh  = '0;
            sticky = |my;
        end else begin
            my_sh  = my >> d;
            sticky = |(my & ((27'd1 << d) - 27'd1));
        end
        my_sh[0] = my_sh[0] | sticky;
        w = eff_sub ? ({1'b0, mx} - {1'b0, my_sh}) : ({1'b0, mx} + {1'b0, my_sh});
        e = {2'b00, big[30:23]};
        lz = '0;
        found = 1'b0;
        if (w[27]) begin
            w = {1'b0, w[27:2], w[1] | w[0]};
            e = e + 10'd1;
        end else begin
            for (int i = 26; i >= 0; i--) begin
                if (w[i] && !found) begin
                    lz = 5'(26 - i);
                    found = 1'b1;
                end
            end
            w = w << lz;
            e = e - {5'd0, lz};
        end
        // A mantissa carry out of rounding ripples straight into the exponent field.
        rnd  = w[2] & (w[1] | w[0] | w[3]);
        body = {e[7:0], w[25:3]} + {30'd0, rnd};
        if (big[30:23] == 8'hFF)    y = {big_s, big};
        else if (w == 28'd0)        y = '0;
        else if ($signed(e) <= 0)   y = {big_s, 31'd0};
        else if (e >= 10'd255)      y = {big_s, 8'hFF, 23'd0};
        else                        y = {big_s, body};
    end
endmodule

// File: rtl/fp_alu_stream.sv
// Streaming FP ALU: operands arrive LSB-beat first, result leaves LSB-beat first.
module fp_alu_stream
    import fp_alu_pkg::*;
#(
    parameter int BUS_W    = 8,
    parameter int EXEC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [BUS_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             op_err,
    output logic [2:0]       state_out
);
    localparam int         BEATS     = 32 / BUS_W;
    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);
    localparam logic [2:0] LAST_EXEC = 3'(EXEC_LAT - 1);

    generate
        if (!bus_w_legal(BUS_W) || !exec_lat_legal(EXEC_LAT)) begin : g_bad_param
            $error("fp_alu_stream: illegal BUS_W or EXEC_LAT");
        end
    endgenerate

    // Handshake: a beat moves on a rising edge only when valid and ready are both high.
    state_t      state;
    opcode_t     op_q;
    logic [2:0]  cnt, exec_cnt;
    logic [31:0] a_q, b_q, result_q;
    logic [31:0] fa, fb, sum;
    logic        fsub;

    always_comb begin
        fa = a_q; fb = b_q; fsub = 1'b0;
        case (op_q)
            OP_SUB:  begin fa = a_q; fb = b_q; fsub = 1'b1; end
            OP_RSUB: begin fa = b_q; fb = a_q; fsub = 1'b1; end
            default: begin fa = a_q; fb = b_q; fsub = 1'b0; end
        endcase
    end

    fp_addsub u_addsub (.a(fa), .b(fb), .sub(fsub), .y(sum));

    assign state_out = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE; op_q <= OP_ADD; cnt <= '0; exec_cnt <= '0;
            a_q <= '0; b_q <= '0; result_q <= '0;
            in_ready <= 1'b0; out_data <= '0; out_valid <= 1'b0; out_last <= 1'b0;
            busy <= 1'b0; op_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    op_q     <= opcode_t'(opcode);
                    cnt      <= '0;
                    op_err   <= (opcode == OP_RSV);
                    state    <= ST_LOAD_A;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                end
                ST_LOAD_A: if (in_valid && in_ready) begin
                    a_q[int'(cnt)*BUS_W +: BUS_W] <= in_data;
                    if (cnt == LAST_BEAT) begin
                        cnt <= '0; state <= ST_LOAD_B;
                    end else cnt <= cnt + 3'd1;
                end
                ST_LOAD_B: if (in_valid && in_ready) begin
                    b_q[int'(cnt)*BUS_W +: BUS_W] <= in_data;
                    if (cnt == LAST_BEAT) begin
                        cnt <= '0; exec_cnt <= '0; in_ready <= 1'b0; state <= ST_EXEC;
                    end else cnt <= cnt + 3'd1;
                end
                ST_EXEC: if (exec_cnt == LAST_EXEC) begin
                    result_q  <= sum;
                    out_data  <= sum[BUS_W-1:0];
                    out_valid <= 1'b1;
                    out_last  <= (LAST_BEAT == 3'd0);
                    state     <= ST_OUT;
                end else exec_cnt <= exec_cnt + 3'd1;
                ST_OUT: if (out_valid && out_ready) begin
                    if (cnt == LAST_BEAT) begin
                        cnt <= '0; out_valid <= 1'b0; out_last <= 1'b0; busy <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt      <= cnt + 3'd1;
                        out_data <= BUS_W'(result_q >> (BUS_W * (int'(cnt) + 1)));
                        out_last <= ((cnt + 3'd1) == LAST_BEAT);
                    end
                end
                default: begin
                    state <= ST_IDLE; cnt <= '0; in_ready <= 1'b0;
                    out_valid <= 1'b0; out_last <= 1'b0; busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_alu_stream.sv
// Directed bench for fp_alu_stream: 8-bit/1-cycle instance plus a 32-bit/4-cycle instance.
module tb_fp_alu_stream;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start, in_valid, in_ready, out_valid, out_ready, out_last, busy, op_err;
    logic [1:0] opcode;
    logic [7:0] in_data, out_data;
    logic [2:0] state_out;

    logic        start_w, in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_last_w, busy_w, op_err_w;
    logic [1:0]  opcode_w;
    logic [31:0] in_data_w, out_data_w;
    logic [2:0]  state_out_w;

    fp_alu_stream #(.BUS_W(8), .EXEC_LAT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .op_err(op_err),
        .state_out(state_out)
    );

    fp_alu_stream #(.BUS_W(32), .EXEC_LAT(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start_w), .opcode(opcode_w), .in_data(in_data_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .out_data(out_data_w), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .out_last(out_last_w), .busy(busy_w), .op_err(op_err_w),
        .state_out(state_out_w)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
        int          gap_max;
        bit          stall;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] data, input int gap_max);
        bit rdy;
        int t;
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) step();
        in_valid = 1'b1;
        in_data = data;
        t = 0;
        do begin
            rdy = in_ready;
            step();
            t++;
        end while (!rdy && t < 40);
        if (!rdy) check("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic recv_all(input bit stall);
        int t;
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q[0];
            t = 0;
            while (!out_valid && t < 40) begin
                step();
                t++;
            end
            if (!out_valid) begin
                check("out_valid_timeout", 32'd0, 32'd1);
                exp_q.delete();
                break;
            end
            if (stall) begin
                repeat (3) begin
                    out_ready = 1'b0;
                    step();
                    check("stall_data", out_data, e);
                    check("stall_valid", out_valid, 32'd1);
                    check("stall_last", out_last, (exp_q.size() == 1));
                end
            end
            check("out_data", out_data, e);
            check("out_last", out_last, (exp_q.size() == 1));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            void'(exp_q.pop_front());
        end
        check("out_valid_done", out_valid, 32'd0);
        check("busy_done", busy, 32'd0);
        check("state_idle", state_out, 32'd0);
    endtask

    task automatic run_op(input vec_t v);
        for (int k = 0; k < 4; k++) exp_q.push_back(v.res[8*k +: 8]);
        opcode = v.op;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_state", state_out, 32'd1);
        check("op_err_latch", op_err, v.err);
        check("busy", busy, 32'd1);
        for (int k = 0; k < 4; k++) send_beat(v.a[8*k +: 8], v.gap_max);
        for (int k = 0; k < 4; k++) send_beat(v.b[8*k +: 8], v.gap_max);
        recv_all(v.stall);
        check("op_err_hold", op_err, v.err);
    endtask

    task automatic send_word32(input logic [31:0] data);
        bit rdy;
        int t;
        in_valid_w = 1'b1;
        in_data_w = data;
        t = 0;
        do begin
            rdy = in_ready_w;
            step();
            t++;
        end while (!rdy && t < 40);
        if (!rdy) check("in_ready32_timeout", 32'd0, 32'd1);
        in_valid_w = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_state", state_out, 32'd0);
        check("rst_in_ready", in_ready, 32'd0);
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_out_last", out_last, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_op_err", op_err, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] stream;
        int idx, cyc;
        bit xfer;

        vecs[0] = '{2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 0, 1'b0};
        vecs[1] = '{2'b01, 32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0, 0, 1'b0};
        vecs[2] = '{2'b10, 32'h3F800000, 32'h40000000, 32'h3F800000, 1'b0, 0, 1'b0};
        vecs[3] = '{2'b11, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1, 0, 1'b0};
        vecs[4] = '{2'b00, 32'h3FC00000, 32'h3E800000, 32'h3FE00000, 1'b0, 3, 1'b1};
        vecs[5] = '{2'b01, 32'h41200000, 32'h40800000, 32'h40C00000, 1'b0, 2, 1'b1};
        vecs[6] = '{2'b10, 32'h40A00000, 32'h3F800000, 32'hC0800000, 1'b0, 1, 1'b0};
        vecs[7] = '{2'b00, 32'h3F800000, 32'hC0400000, 32'hC0000000, 1'b0, 0, 1'b0};
        vecs[8] = '{2'b01, 32'h40000000, 32'h40000000, 32'h00000000, 1'b0, 0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0; opcode = 2'b00; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        start_w = 1'b0; opcode_w = 2'b00; in_data_w = '0; in_valid_w = 1'b0; out_ready_w = 1'b0;
        repeat (3) step();
        check_reset_values();
        check("rst_state32", state_out_w, 32'd0);
        check("rst_out_valid32", out_valid_w, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_op(vecs[i]);

        // Zero-stall latency: start edge is cycle T, EXEC seen after 9 edges, out_valid after 10.
        stream = {32'h40000000, 32'h3F800000};
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(32'h40400000 >> (8 * k)));
        idx = 0;
        cyc = 0;
        opcode = 2'b00;
        start = 1'b1;
        in_valid = 1'b1;
        in_data = stream[7:0];
        while (!out_valid && cyc < 40) begin
            xfer = in_valid && in_ready;
            step();
            cyc++;
            start = 1'b0;
            if (xfer) begin
                idx++;
                if (idx == 8) in_valid = 1'b0;
                else in_data = stream[8*idx +: 8];
            end
            if (cyc == 9) check("exec_state", state_out, 32'd3);
        end
        check("latency8", cyc, 32'd10);
        recv_all(1'b0);

        // Reset during the third B beat of a reserved-op run.
        opcode = 2'b11;
        start = 1'b1;
        step();
        start = 1'b0;
        check("rsv_err_before", op_err, 32'd1);
        for (int k = 0; k < 4; k++) send_beat(8'h11 + 8'(k), 0);
        for (int k = 0; k < 2; k++) send_beat(8'h55 + 8'(k), 0);
        check("mid_state_load_b", state_out, 32'd2);
        in_valid = 1'b1;
        in_data = 8'h77;
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        run_op(vecs[0]);

        // Wide instance: one beat per operand, out_valid in the fifth cycle after the B beat.
        opcode_w = 2'b00;
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        check("start_state32", state_out_w, 32'd1);
        send_word32(32'h3F800000);
        send_word32(32'h40000000);
        cyc = 1;
        while (!out_valid_w && cyc < 20) begin
            step();
            cyc++;
        end
        check("latency32", cyc, 32'd5);
        check("out_data32", out_data_w, 32'h40400000);
        check("out_last32", out_last_w, 32'd1);
        out_ready_w = 1'b1;
        step();
        out_ready_w = 1'b0;
        check("out_valid32_done", out_valid_w, 32'd0);
        check("busy32_done", busy_w, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
